// File: rtl/fetch_unit.sv
// Instruction fetch: one word per cycle into a registered slot; fetches one cycle after a request is accepted by memory.
// Stall holds the slot and drops IMemReq; a redirect overrides Stall and memory, with one FLUSH bubble.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  input  logic        IMemReady,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        InstrValid,
  output logic        Fault
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        accept;
  logic        consume;

  // Only request when the slot is empty or is being drained this cycle.
  assign IMemReq  = (state == FETCH) && (!InstrValid || !Stall);
  assign IMemAddr = fetch_pc;
  assign accept   = IMemReq && IMemReady && !BranchTaken;
  assign consume  = InstrValid && !Stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      PC          <= RESET_PC;
      Instruction <= NOP;
      InstrValid  <= 1'b0;
      Fault       <= 1'b0;
    end else if (state != HALT && BranchTaken) begin
      InstrValid  <= 1'b0;
      Instruction <= NOP;
      if (BranchTarget[1:0] != 2'b00) begin
        Fault <= 1'b1;
        state <= HALT;
      end else begin
        fetch_pc <= BranchTarget;
        state    <= FLUSH;
      end
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FLUSH: state <= FETCH;
        FETCH: begin
          if (accept) begin
            Instruction <= IMemRdata;
            PC          <= fetch_pc;
            InstrValid  <= 1'b1;
            fetch_pc    <= fetch_pc + 32'd4;
          end else if (consume) begin
            InstrValid  <= 1'b0;
            Instruction <= NOP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by random traffic, checked against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRdata;
  logic        IMemReady = 1'b1;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        InstrValid;
  logic        Fault;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  assign IMemRdata = IMemReady ? word_at(IMemAddr) : 32'hDEADBEEF;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemRdata(IMemRdata), .IMemReady(IMemReady), .Instruction(Instruction),
    .PC(PC), .InstrValid(InstrValid), .Fault(Fault)
  );

  // Behavioural model: bubbles remaining before fetching, halted flag, and the slot contents.
  int          m_wait   = 1;
  bit          m_halted = 1'b0;
  logic [31:0] m_fpc    = 32'h0;
  logic [31:0] m_pc     = 32'h0;
  logic [31:0] m_instr  = NOP;
  bit          m_valid  = 1'b0;
  bit          m_fault  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit exp_req;
    #1;
    exp_req = !m_halted && (m_wait == 0) && (!m_valid || !Stall);
    if (!RST) begin
      chk("imemreq", {31'b0, IMemReq}, {31'b0, exp_req});
      if (exp_req) chk("imemaddr", IMemAddr, m_fpc);
    end
    if (RST) begin
      m_wait = 1; m_halted = 0; m_fpc = 32'h0; m_pc = 32'h0;
      m_instr = NOP; m_valid = 0; m_fault = 0;
    end else if (m_halted) begin
      // everything but reset is ignored
    end else if (BranchTaken) begin
      m_valid = 0;
      m_instr = NOP;
      if (BranchTarget % 4 != 0) begin
        m_fault = 1; m_halted = 1;
      end else begin
        m_fpc = BranchTarget; m_wait = 1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (exp_req && IMemReady) begin
      m_instr = word_at(m_fpc);
      m_pc    = m_fpc;
      m_valid = 1;
      m_fpc   = m_fpc + 32'd4;
    end else if (m_valid && !Stall) begin
      m_valid = 0;
      m_instr = NOP;
    end
    @(posedge CLK);
    #1;
    chk("instruction", Instruction, m_instr);
    chk("pc", PC, m_pc);
    chk("instrvalid", {31'b0, InstrValid}, {31'b0, m_valid});
    chk("fault", {31'b0, Fault}, {31'b0, m_fault});
  endtask

  initial begin
    logic [31:0] t;

    // Reset with memory ready: ignored
    RST = 1; IMemReady = 1;
    tick(); tick();
    chk("rst_instr", Instruction, NOP);
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'b0, InstrValid}, 32'h0);
    chk("rst_fault", {31'b0, Fault}, 32'h0);

    // Streaming fetch: IDLE cycle, then one word per cycle
    RST = 0;
    tick();
    chk("idle_req", {31'b0, IMemReq}, 32'h1);
    tick(); chk("seq_pc0", PC, 32'h0); chk("seq_v0", {31'b0, InstrValid}, 32'h1);
    tick(); chk("seq_pc4", PC, 32'h4);
    tick(); chk("seq_pc8", PC, 32'h8);
    chk("seq_instr8", Instruction, word_at(32'h8));

    // Stall holds the slot at 8
    Stall = 1;
    repeat (3) begin
      tick();
      chk("stall_pc", PC, 32'h8);
      chk("stall_req", {31'b0, IMemReq}, 32'h0);
    end
    Stall = 0;
    tick(); chk("unstall_pc", PC, 32'hC);

    // Redirect overriding Stall and a same-cycle ready
    BranchTaken = 1; BranchTarget = 32'h100; Stall = 1; IMemReady = 1;
    tick();
    chk("br_valid", {31'b0, InstrValid}, 32'h0);
    chk("br_nop", Instruction, NOP);
    BranchTaken = 0; Stall = 0;
    tick(); chk("bubble_valid", {31'b0, InstrValid}, 32'h0);
    tick(); chk("br_pc100", PC, 32'h100);
    tick(); chk("br_pc104", PC, 32'h104);

    // Memory not ready for 4 cycles
    IMemReady = 0;
    repeat (4) begin
      tick();
      chk("wait_addr", IMemAddr, 32'h108);
    end
    chk("wait_valid", {31'b0, InstrValid}, 32'h0);
    IMemReady = 1;
    tick(); chk("ready_pc", PC, 32'h108);
    chk("ready_instr", Instruction, word_at(32'h108));

    // Wrap at top of address space
    BranchTaken = 1; BranchTarget = 32'hFFFFFFFC;
    tick();
    BranchTaken = 0;
    tick(); tick(); chk("wrap_top", PC, 32'hFFFFFFFC);
    tick(); chk("wrap_zero", PC, 32'h0);

    // Misaligned redirect halts until reset
    BranchTaken = 1; BranchTarget = 32'h102;
    tick();
    chk("fault_set", {31'b0, Fault}, 32'h1);
    repeat (6) begin
      BranchTaken = $urandom_range(0, 1); BranchTarget = $urandom & ~32'h3;
      Stall = $urandom_range(0, 1); IMemReady = 1;
      tick();
      chk("halt_req", {31'b0, IMemReq}, 32'h0);
    end
    BranchTaken = 0; Stall = 0;
    RST = 1; tick();
    chk("fault_clr", {31'b0, Fault}, 32'h0);
    RST = 0;
    tick(); tick(); chk("restart_pc", PC, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      RST = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      Stall = ($urandom_range(0, 2) == 0);
      IMemReady = ($urandom_range(0, 3) != 0);
      BranchTaken = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 15))
        0: begin t = $urandom; t[0] = 1'b1; end
        1: t = $urandom_range(0, 1) ? 32'hFFFFFFFC : 32'hFFFFFFF8;
        default: t = $urandom & 32'h0000FFFC;
      endcase
      BranchTarget = t;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
